// File: rtl/hs_cdc_rx.sv
// Destination end of a toggle req/ack handshake: synchronizes the request toggle, captures the
// quasi-static data bus, and returns an ack toggle. Optional protocol check: HS_CDC_RX_PROTO_CHECK_EN.
module hs_cdc_rx #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk_dst,
   input  logic             rst_n_dst,
   input  logic             req_tgl_in,
   input  logic [WIDTH-1:0] data_in,
   output logic             ack_tgl_out,
   output logic [WIDTH-1:0] dst_data,
   output logic             dst_valid,
   input  logic             dst_ready,
   output logic             proto_err
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_VALID = 1'b1
   } state_t;

   state_t state_q, state_d;

   (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

   logic             req_sync;
   logic             req_pending;
   logic             req_seen_q, req_seen_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             ack_q, ack_d;

   assign req_sync    = sync_q[STAGES-1];
   assign req_pending = (req_sync != req_seen_q);

   always_ff @(posedge clk_dst or negedge rst_n_dst) begin
      if (!rst_n_dst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], req_tgl_in};
      end
   end

   always_ff @(posedge clk_dst or negedge rst_n_dst) begin
      if (!rst_n_dst) begin
         state_q    <= ST_IDLE;
         req_seen_q <= 1'b0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         ack_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_seen_q <= req_seen_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         ack_q      <= ack_d;
      end
   end

   // data_in is sampled unsynchronized: the source keeps it stable until it sees our ack.
   always_comb begin
      state_d    = state_q;
      req_seen_d = req_seen_q;
      data_d     = data_q;
      valid_d    = valid_q;
      ack_d      = ack_q;
      case (state_q)
         ST_IDLE: begin
            if (req_pending) begin
               data_d     = data_in;
               valid_d    = 1'b1;
               req_seen_d = req_sync;
               state_d    = ST_VALID;
            end
         end
         ST_VALID: begin
            if (valid_q && dst_ready) begin
               valid_d = 1'b0;
               ack_d   = ~ack_q;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign ack_tgl_out = ack_q;
   assign dst_data    = data_q;
   assign dst_valid   = valid_q;

`ifdef HS_CDC_RX_PROTO_CHECK_EN
   logic req_sync_d_q;
   logic proto_err_q;

   // Any req edge while a word is outstanding means the source did not wait for ack.
   always_ff @(posedge clk_dst or negedge rst_n_dst) begin
      if (!rst_n_dst) begin
         req_sync_d_q <= 1'b0;
         proto_err_q  <= 1'b0;
      end else begin
         req_sync_d_q <= req_sync;
         if ((state_q == ST_VALID) && (req_sync != req_sync_d_q)) begin
            proto_err_q <= 1'b1;
         end
      end
   end

   assign proto_err = proto_err_q;

`ifndef SYNTHESIS
   always @(posedge clk_dst) begin
      if (rst_n_dst) begin
         assert (!((state_q == ST_VALID) && (req_sync != req_sync_d_q)))
            else $warning("hs_cdc_rx: request toggled while a word was outstanding");
      end
   end
`endif
`else
   assign proto_err = 1'b0;
`endif

endmodule

// File: doc/hs_cdc_rx.md
Name: hs_cdc_rx

Overview:
- Destination (responder) end of a toggle-based req/ack handshake that moves a multi-bit word into the clk_dst domain.
- Synchronizes the source's request toggle and captures the quasi-static data bus.
- Presents the word on a valid/ready interface and returns an acknowledge toggle to the source domain.
- Used where bit-level synchronizers cannot be used, e.g. UART config/status words crossing clock domains.

Parameters:
- WIDTH, 8, width of transferred data word
- STAGES, 2, synchronizer flops on req_tgl_in; legal values 2 or 3

Ports:
- clk_dst  input  1  destination clock
- rst_n_dst  input  1  asynchronous active-low reset, clk_dst domain
- req_tgl_in  input  1  asynchronous request toggle from source; each level change = one new word
- data_in  input  WIDTH  asynchronous data bus; source holds it stable from before its req toggle until it sees ack
- ack_tgl_out  output  1  acknowledge toggle to source domain, driven directly from a flop
- dst_data  output  WIDTH  captured word, clk_dst domain
- dst_valid  output  1  dst_data holds an unconsumed word
- dst_ready  input  1  consumer accepts the word when dst_valid && dst_ready
- proto_err  output  1  sticky protocol-violation flag; see Optional Feature

Behaviour:
- Reset: clk_dst is clock, rst_n_dst is reset, asynchronous active-low. All flops clear.
  - Reset values: dst_valid=0, dst_data=0, ack_tgl_out=0, proto_err=0, req_seen=0, sync chain=0, FSM=IDLE.
- Synchronizer: req_tgl_in passes through an STAGES-deep chain marked ASYNC_REG to give req_sync. req_sync_d is req_sync delayed one cycle.
- req_seen register: holds the req level last accepted.
- Pending request: req_sync != req_seen.
- data_in is never synchronized. It is sampled only when a pending request is first seen in IDLE; the handshake guarantees it is stable then.
- FSM IDLE:
  - If a request is pending: dst_data <= data_in, dst_valid <= 1, req_seen <= req_sync, go VALID.
  - Otherwise hold.
- FSM VALID:
  - dst_valid=1 and dst_data held constant.
  - On dst_valid && dst_ready: dst_valid <= 0, ack_tgl_out <= ~ack_tgl_out, go IDLE.
  - With dst_ready low: remain indefinitely. Backpressure stalls the ack, and therefore stalls the source.
- Latency:
  - req_tgl_in toggle to dst_valid high: STAGES+1 clk_dst edges after the first sampling edge (3 for STAGES=2).
  - Accept to ack_tgl_out toggle: 1 cycle (registered).
- Back-to-back: a request pending on the first IDLE cycle after an accept is captured that cycle. Throughput is bounded by the source round trip, not by this block.
- dst_ready high in IDLE: no effect.
- dst_ready held high continuously: each word is valid for exactly 1 cycle.
- Second req toggle while in VALID is a protocol violation. Data is not recaptured. The extra toggle cancels in req_sync, so no further word is produced for it.
- Reset mid-transfer: word discarded, ack_tgl_out returns to 0. Source and destination must be reset together; this block does not resynchronize toggle phase.
- ack_tgl_out is glitch-free: single flop, no combinational path.

Optional Feature:
- Macro: HS_CDC_RX_PROTO_CHECK_EN.
- Defined:
  - proto_err sets when FSM=VALID and req_sync != req_sync_d.
  - Sticky until reset.
  - A simulation-only assertion also fires on the same condition.
- Undefined:
  - proto_err tied to 0.
  - No req_sync_d flop; no check logic or assertion.

Test Plan:
- Basic transfer, STAGES=2, dst_ready=1: data_in=0xA5, toggle req_tgl_in 0->1 → dst_valid high 1 cycle on edge 3 with dst_data=0xA5; ack_tgl_out 0->1 one cycle later.
- Backpressure: dst_ready=0, word 0x3C delivered → dst_valid and dst_data=0x3C held 20 cycles, ack_tgl_out unchanged; raise dst_ready → accept, ack toggles next cycle, dst_valid=0.
- Stream of 4 words 0x01,0x02,0x04,0x08 from a source model in a 3.7x-slower async clock doing proper req/ack → 4 accepts in order, ack toggles 4 times (final level 0), proto_err=0.
- Violation, macro defined: dst_ready=0, toggle req twice while in VALID → proto_err=1 and stays 1; dst_data unchanged; after accept no extra dst_valid.
- Reset mid-operation: assert rst_n_dst while dst_valid=1, ack_tgl_out=1 → immediately dst_valid=0, dst_data=0, ack_tgl_out=0; after release with req_tgl_in=0 → no spurious dst_valid.
- STAGES=3: single toggle → dst_valid rises on edge 4; data_in changed after ack → dst_data unaffected.
